// File: rtl/controlador_de_io.sv
// controlador_de_io
// Sequential companion to the combinational control unit. Carries out the I/O
// side effects of the WAIT, INPUT and OUTPUT opcodes:
//   - WAIT   (ler_da_entrada):   stalls the PC until the user presses and
//            releases the push-button, then captures the switch value.
//   - INPUT  (confirma_entrada): presents the captured value to the register
//            write mux in the same cycle (never stalls).
//   - OUTPUT (print):            latches dado_reg for the display driver.
//
// Ports:
//   clock            in   system clock, all state on its rising edge
//   reset            in   asynchronous reset, active-low
//   ler_da_entrada   in   WAIT decoded
//   confirma_entrada in   INPUT decoded
//   print            in   OUTPUT decoded
//   botao            in   raw push-button, active-high, asynchronous
//   chaves           in   raw switch bus [LARGURA_CHAVES-1:0]
//   dado_reg         in   register-file read value for OUTPUT [31:0]
//   stall            out  freeze PC / suppress writeback while high
//   dado_entrada     out  value for the register write mux on INPUT [31:0]
//   saida_display    out  last printed value [31:0]
//   saida_valida     out  sticky: at least one OUTPUT since reset
//   aguardando       out  LED: waiting for the user to press the button
//   num_entradas     out  count of confirmed WAITs, wraps 255->0 [7:0]

module controlador_de_io #(
  parameter int unsigned LARGURA_CHAVES  = 16,
  parameter int unsigned DEBOUNCE_CICLOS = 50000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      ler_da_entrada,
  input  logic                      confirma_entrada,
  input  logic                      print,
  input  logic                      botao,
  input  logic [LARGURA_CHAVES-1:0] chaves,
  input  logic [31:0]               dado_reg,
  output logic                      stall,
  output logic [31:0]               dado_entrada,
  output logic [31:0]               saida_display,
  output logic                      saida_valida,
  output logic                      aguardando,
  output logic [7:0]                num_entradas
);

  localparam int unsigned     CW      = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CICLOS - 1);

  localparam logic [1:0] OCIOSO        = 2'd0;
  localparam logic [1:0] ESPERA_APERTO = 2'd1;
  localparam logic [1:0] ESPERA_SOLTAR = 2'd2;
  localparam logic [1:0] CONCLUI       = 2'd3;

  // ---------------------------------------------------------------------------
  // Button path: 2-FF synchroniser + debouncer + rising-edge detector
  // ---------------------------------------------------------------------------
  logic          sync1_q, sync2_q;
  logic          botao_limpo_q, botao_limpo_d;
  logic          botao_limpo_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          subida;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q            <= 1'b0;
      sync2_q            <= 1'b0;
      botao_limpo_q      <= 1'b0;
      botao_limpo_prev_q <= 1'b0;
      cnt_q              <= '0;
    end else begin
      sync1_q            <= botao;
      sync2_q            <= sync1_q;
      botao_limpo_q      <= botao_limpo_d;
      botao_limpo_prev_q <= botao_limpo_q;
      cnt_q              <= cnt_d;
    end
  end

  // The counter measures how long the synced level has disagreed with the
  // debounced level; any agreement restarts the measurement. The toggle edge
  // is the one at which the count already equals DEBOUNCE_CICLOS-1, giving
  // exactly DEBOUNCE_CICLOS consecutive mismatching cycles.
  always_comb begin
    botao_limpo_d = botao_limpo_q;
    cnt_d         = '0;
    if (sync2_q != botao_limpo_q) begin
      if (cnt_q == CNT_MAX) begin
        botao_limpo_d = ~botao_limpo_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign subida = botao_limpo_q & ~botao_limpo_prev_q;

  // ---------------------------------------------------------------------------
  // WAIT sequencing FSM, capture register and confirmed-WAIT counter
  // ---------------------------------------------------------------------------
  logic [1:0]  estado_q, estado_d;
  logic [31:0] dado_capturado_q, dado_capturado_d;
  logic [7:0]  num_entradas_q, num_entradas_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q         <= OCIOSO;
      dado_capturado_q <= '0;
      num_entradas_q   <= '0;
    end else begin
      estado_q         <= estado_d;
      dado_capturado_q <= dado_capturado_d;
      num_entradas_q   <= num_entradas_d;
    end
  end

  // Only a rising edge seen while already in ESPERA_APERTO counts, so a button
  // that is held when the WAIT arrives needs a release and a fresh press.
  always_comb begin
    estado_d         = estado_q;
    dado_capturado_d = dado_capturado_q;
    num_entradas_d   = num_entradas_q;
    unique case (estado_q)
      OCIOSO: begin
        if (ler_da_entrada) estado_d = ESPERA_APERTO;
      end
      ESPERA_APERTO: begin
        if (subida) begin
          dado_capturado_d = 32'(chaves);
          num_entradas_d   = num_entradas_q + 8'd1;
          estado_d         = ESPERA_SOLTAR;
        end
      end
      ESPERA_SOLTAR: begin
        if (!botao_limpo_q) estado_d = CONCLUI;
      end
      CONCLUI: begin
        estado_d = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  // Stall is asserted in the very cycle a WAIT is decoded in OCIOSO so the PC
  // never slips past it; CONCLUI releases it for exactly one edge.
  assign stall = ((estado_q == OCIOSO) && ler_da_entrada)
              || (estado_q == ESPERA_APERTO)
              || (estado_q == ESPERA_SOLTAR);

  assign aguardando   = (estado_q == ESPERA_APERTO);
  assign dado_entrada = confirma_entrada ? dado_capturado_q : '0;
  assign num_entradas = num_entradas_q;

  // ---------------------------------------------------------------------------
  // OUTPUT: display latch and sticky valid flag (independent of stall)
  // ---------------------------------------------------------------------------
  logic [31:0] saida_display_q, saida_display_d;
  logic        saida_valida_q, saida_valida_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      saida_display_q <= '0;
      saida_valida_q  <= 1'b0;
    end else begin
      saida_display_q <= saida_display_d;
      saida_valida_q  <= saida_valida_d;
    end
  end

  always_comb begin
    saida_display_d = saida_display_q;
    saida_valida_d  = saida_valida_q;
    if (print) begin
      saida_display_d = dado_reg;
      saida_valida_d  = 1'b1;
    end
  end

  assign saida_display = saida_display_q;
  assign saida_valida  = saida_valida_q;

endmodule

// File: tb/tb_controlador_de_io.sv
module tb_controlador_de_io;

  logic        clock;
  logic        reset;
  logic        ler_da_entrada;
  logic        confirma_entrada;
  logic        print;
  logic        botao;
  logic [15:0] chaves;
  logic [31:0] dado_reg;
  logic        stall;
  logic [31:0] dado_entrada;
  logic [31:0] saida_display;
  logic        saida_valida;
  logic        aguardando;
  logic [7:0]  num_entradas;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];

  controlador_de_io #(
    .LARGURA_CHAVES (16),
    .DEBOUNCE_CICLOS(4)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .ler_da_entrada  (ler_da_entrada),
    .confirma_entrada(confirma_entrada),
    .print           (print),
    .botao           (botao),
    .chaves          (chaves),
    .dado_reg        (dado_reg),
    .stall           (stall),
    .dado_entrada    (dado_entrada),
    .saida_display   (saida_display),
    .saida_valida    (saida_valida),
    .aguardando      (aguardando),
    .num_entradas    (num_entradas)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Press and hold until the FSM leaves ESPERA_APERTO; returns edges taken.
  task automatic press_wait(output int cyc);
    botao = 1'b1;
    cyc = 0;
    while (aguardando && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  // Release and run until stall drops (CONCLUI); returns edges taken.
  task automatic release_wait(output int cyc);
    botao = 1'b0;
    cyc = 0;
    while (stall && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    ler_da_entrada = 1'b0;
    confirma_entrada = 1'b0;
    print = 1'b0;
    botao = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    ler_da_entrada = 1'b0;
    confirma_entrada = 1'b0;
    print = 1'b0;
    botao = 1'b0;
    chaves = 16'hFFFF;
    dado_reg = 32'h0;
    #3;
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_tests++; if (aguardando !== 1'b0) begin n_fail++; $display("FAIL reset_aguardando: got %b want 0", aguardando); end
    n_tests++; if (num_entradas !== 8'd0) begin n_fail++; $display("FAIL reset_num: got %0d want 0", num_entradas); end
    n_tests++; if (saida_valida !== 1'b0) begin n_fail++; $display("FAIL reset_valida: got %b want 0", saida_valida); end
    n_tests++; if (saida_display !== 32'h0) begin n_fail++; $display("FAIL reset_display: got %h want 0", saida_display); end
    repeat (2) tick();
    reset = 1'b1;
    tick();
    confirma_entrada = 1'b1;
    #1;
    n_tests++; if (dado_entrada !== 32'h0) begin n_fail++; $display("FAIL input_before_wait: got %h want 0", dado_entrada); end
    confirma_entrada = 1'b0;
    tick();
  endtask

  task automatic test_debounce();
    logic exp;
    botao = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp = (k >= 6);
      n_tests++;
      if (dut.botao_limpo_q !== exp) begin
        n_fail++; $display("FAIL debounce_rise_edge%0d: got %b want %b", k, dut.botao_limpo_q, exp);
      end
    end
    botao = 1'b0;
    repeat (8) tick();
    n_tests++; if (dut.botao_limpo_q !== 1'b0) begin n_fail++; $display("FAIL debounce_fall: got %b want 0", dut.botao_limpo_q); end
    // 3-cycle glitch must be ignored
    botao = 1'b1;
    repeat (3) tick();
    botao = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      n_tests++;
      if (dut.botao_limpo_q !== 1'b0) begin
        n_fail++; $display("FAIL debounce_glitch_edge%0d: got %b want 0", k, dut.botao_limpo_q);
      end
    end
  endtask

  task automatic test_wait_input();
    int cyc;
    chaves = 16'h00A5;
    ler_da_entrada = 1'b1;
    #1;
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL wait_stall_ocioso: got %b want 1", stall); end
    tick();
    n_tests++; if (aguardando !== 1'b1) begin n_fail++; $display("FAIL wait_aguardando: got %b want 1", aguardando); end
    botao = 1'b1;
    exp_q.push_back(32'h0000_00A5);
    cyc = 0;
    while (aguardando && cyc < 40) begin
      n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL wait_stall_press: got %b want 1", stall); end
      tick();
      cyc++;
    end
    // 2 sync + 4 debounce edges to botao_limpo, one more for the FSM to see subida
    n_tests++; if (cyc !== 7) begin n_fail++; $display("FAIL wait_press_latency: got %0d want 7", cyc); end
    n_tests++; if (num_entradas !== 8'd1) begin n_fail++; $display("FAIL wait_num_after_press: got %0d want 1", num_entradas); end
    botao = 1'b0;
    cyc = 0;
    while (stall && cyc < 40) begin
      n_tests++; if (aguardando !== 1'b0) begin n_fail++; $display("FAIL wait_aguardando_release: got %b want 0", aguardando); end
      tick();
      cyc++;
    end
    n_tests++; if (cyc !== 7) begin n_fail++; $display("FAIL wait_release_latency: got %0d want 7", cyc); end
    n_tests++; if (num_entradas !== 8'd1) begin n_fail++; $display("FAIL wait_num_conclui: got %0d want 1", num_entradas); end
    ler_da_entrada = 1'b0;
    tick();
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL wait_after_conclui: got %b want 0", stall); end
    confirma_entrada = 1'b1;
    #1;
    if (exp_q.size() == 0) begin
      n_tests++; n_fail++; $display("FAIL wait_input_sb: scoreboard empty");
    end else begin
      logic [31:0] e;
      e = exp_q.pop_front();
      n_tests++; if (dado_entrada !== e) begin n_fail++; $display("FAIL wait_input_value: got %h want %h", dado_entrada, e); end
    end
    confirma_entrada = 1'b0;
    tick();
  endtask

  task automatic test_held_button();
    int cyc;
    botao = 1'b1;
    repeat (8) tick();
    chaves = 16'h1234;
    ler_da_entrada = 1'b1;
    tick();
    for (int k = 0; k < 12; k++) begin
      n_tests++;
      if (aguardando !== 1'b1 || stall !== 1'b1 || num_entradas !== 8'd1) begin
        n_fail++; $display("FAIL held_no_capture: aguardando=%b stall=%b num=%0d want 1 1 1", aguardando, stall, num_entradas);
      end
      tick();
    end
    botao = 1'b0;
    repeat (8) tick();
    n_tests++; if (aguardando !== 1'b1) begin n_fail++; $display("FAIL held_after_release: got %b want 1", aguardando); end
    exp_q.push_back(32'h0000_1234);
    press_wait(cyc);
    n_tests++; if (cyc >= 40) begin n_fail++; $display("FAIL held_press_timeout: got %0d edges want <40", cyc); end
    n_tests++; if (num_entradas !== 8'd2) begin n_fail++; $display("FAIL held_num: got %0d want 2", num_entradas); end
    release_wait(cyc);
    n_tests++; if (cyc >= 40) begin n_fail++; $display("FAIL held_release_timeout: got %0d edges want <40", cyc); end
    ler_da_entrada = 1'b0;
    tick();
    confirma_entrada = 1'b1;
    #1;
    if (exp_q.size() == 0) begin
      n_tests++; n_fail++; $display("FAIL held_input_sb: scoreboard empty");
    end else begin
      logic [31:0] e;
      e = exp_q.pop_front();
      n_tests++; if (dado_entrada !== e) begin n_fail++; $display("FAIL held_input_value: got %h want %h", dado_entrada, e); end
    end
    confirma_entrada = 1'b0;
    tick();
  endtask

  task automatic test_output();
    logic [31:0] e;
    print = 1'b1;
    dado_reg = 32'hDEAD_BEEF;
    exp_q.push_back(32'hDEAD_BEEF);
    tick();
    print = 1'b0;
    e = exp_q.pop_front();
    n_tests++; if (saida_display !== e) begin n_fail++; $display("FAIL output_display: got %h want %h", saida_display, e); end
    n_tests++; if (saida_valida !== 1'b1) begin n_fail++; $display("FAIL output_valida: got %b want 1", saida_valida); end
    dado_reg = 32'h1234_5678;
    repeat (2) tick();
    n_tests++; if (saida_display !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL output_hold: got %h want deadbeef", saida_display); end
    n_tests++; if (saida_valida !== 1'b1) begin n_fail++; $display("FAIL output_sticky: got %b want 1", saida_valida); end
  endtask

  task automatic test_print_wait_reset();
    int cyc;
    logic [31:0] e;
    ler_da_entrada = 1'b1;
    print = 1'b1;
    dado_reg = 32'hCAFE_F00D;
    exp_q.push_back(32'hCAFE_F00D);
    #1;
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL simul_stall: got %b want 1", stall); end
    tick();
    print = 1'b0;
    e = exp_q.pop_front();
    n_tests++; if (saida_display !== e) begin n_fail++; $display("FAIL simul_display: got %h want %h", saida_display, e); end
    n_tests++; if (aguardando !== 1'b1) begin n_fail++; $display("FAIL simul_aguardando: got %b want 1", aguardando); end
    confirma_entrada = 1'b1;
    #1;
    n_tests++; if (dado_entrada !== 32'h0000_1234) begin n_fail++; $display("FAIL input_during_stall: got %h want 00001234", dado_entrada); end
    confirma_entrada = 1'b0;
    press_wait(cyc);
    n_tests++; if (cyc >= 40) begin n_fail++; $display("FAIL rst_press_timeout: got %0d edges want <40", cyc); end
    n_tests++; if (stall !== 1'b1 || num_entradas !== 8'd3) begin n_fail++; $display("FAIL rst_in_soltar: stall=%b num=%0d want 1 3", stall, num_entradas); end
    #2;
    reset = 1'b0;
    ler_da_entrada = 1'b0;
    botao = 1'b0;
    #1;
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stall: got %b want 0", stall); end
    n_tests++; if (saida_valida !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valida: got %b want 0", saida_valida); end
    n_tests++; if (num_entradas !== 8'd0) begin n_fail++; $display("FAIL rst_mid_num: got %0d want 0", num_entradas); end
    n_tests++; if (aguardando !== 1'b0) begin n_fail++; $display("FAIL rst_mid_aguardando: got %b want 0", aguardando); end
    confirma_entrada = 1'b1;
    #1;
    n_tests++; if (dado_entrada !== 32'h0) begin n_fail++; $display("FAIL rst_mid_capture: got %h want 0", dado_entrada); end
    confirma_entrada = 1'b0;
    repeat (2) tick();
    #2;
    ler_da_entrada = 1'b1;
    reset = 1'b1;
    #1;
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rst_release_stall: got %b want 1", stall); end
    tick();
    n_tests++; if (aguardando !== 1'b1) begin n_fail++; $display("FAIL rst_release_aguardando: got %b want 1", aguardando); end
    chaves = 16'h0F0F;
    press_wait(cyc);
    release_wait(cyc);
    ler_da_entrada = 1'b0;
    tick();
    n_tests++; if (num_entradas !== 8'd1) begin n_fail++; $display("FAIL rst_then_wait_num: got %0d want 1", num_entradas); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    ler_da_entrada = 1'b1;
    tick();
    press_wait(cyc);
    release_wait(cyc);
    n_tests++; if (stall !== 1'b0 || num_entradas !== 8'd2) begin n_fail++; $display("FAIL b2b_first: stall=%b num=%0d want 0 2", stall, num_entradas); end
    tick();
    n_tests++; if (stall !== 1'b1 || aguardando !== 1'b0) begin n_fail++; $display("FAIL b2b_fresh: stall=%b aguardando=%b want 1 0", stall, aguardando); end
    tick();
    for (int k = 0; k < 10; k++) begin
      n_tests++;
      if (aguardando !== 1'b1 || num_entradas !== 8'd2) begin
        n_fail++; $display("FAIL b2b_needs_press: aguardando=%b num=%0d want 1 2", aguardando, num_entradas);
      end
      tick();
    end
    press_wait(cyc);
    release_wait(cyc);
    n_tests++; if (cyc >= 40 || num_entradas !== 8'd3) begin n_fail++; $display("FAIL b2b_second: cyc=%0d num=%0d want <40 3", cyc, num_entradas); end
    ler_da_entrada = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    int cyc;
    int timeouts;
    logic [31:0] e;
    apply_reset();
    timeouts = 0;
    for (int i = 0; i < 256; i++) begin
      chaves = 16'(i) ^ 16'hA000;
      if (i == 255) exp_q.push_back(32'(16'(i) ^ 16'hA000));
      ler_da_entrada = 1'b1;
      tick();
      press_wait(cyc);
      if (cyc >= 40) timeouts++;
      release_wait(cyc);
      if (cyc >= 40) timeouts++;
      ler_da_entrada = 1'b0;
      tick();
      if (i == 254) begin
        n_tests++; if (num_entradas !== 8'd255) begin n_fail++; $display("FAIL wrap_255: got %0d want 255", num_entradas); end
      end
    end
    n_tests++; if (timeouts !== 0) begin n_fail++; $display("FAIL wrap_timeouts: got %0d want 0", timeouts); end
    n_tests++; if (num_entradas !== 8'd0) begin n_fail++; $display("FAIL wrap_zero: got %0d want 0", num_entradas); end
    confirma_entrada = 1'b1;
    #1;
    e = exp_q.pop_front();
    n_tests++; if (dado_entrada !== e) begin n_fail++; $display("FAIL wrap_last_capture: got %h want %h", dado_entrada, e); end
    confirma_entrada = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    ler_da_entrada = 1'b0;
    confirma_entrada = 1'b0;
    print = 1'b0;
    botao = 1'b0;
    chaves = '0;
    dado_reg = '0;
    test_reset();
    test_debounce();
    test_wait_input();
    test_held_button();
    test_output();
    test_print_wait_reset();
    test_back_to_back();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
